// File: rtl/conv_pkg.sv
// Shared constants and reader state encoding for the 3x3 convolution result path.
package conv_pkg;

    localparam int unsigned RES_W       = 23;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned OUT_DIM     = 222;
    localparam int unsigned NUM_RESULTS = OUT_DIM * OUT_DIM;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } reader_state_e;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
module result_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_wr, do_rd;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        do_wr   = wr_en && (count_q != CntW'(DEPTH));
        do_rd   = rd_en && (count_q != '0);
        empty   = (count_q == '0);
        count   = count_q;
        rd_data = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= bump(wr_ptr_q);
            if (do_rd) rd_ptr_q <= bump(rd_ptr_q);
            count_q <= count_q + CntW'(do_wr) - CntW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/conv_result_reader.sv
// Sweeps the convolution result BRAM after the engine finishes and streams each
// result with row/frame markers and a saturated 8-bit pixel.
module conv_result_reader #(
    parameter int unsigned OUT_DIM    = 222,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          rd_en,
    output logic [conv_pkg::ADDR_W-1:0]   rd_addr,
    input  logic [conv_pkg::RES_W-1:0]    rd_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [conv_pkg::RES_W-1:0]    m_data,
    output logic [7:0]                    m_pix,
    output logic                          m_row_end,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done
);

    import conv_pkg::*;

    localparam int unsigned NumBeats = OUT_DIM * OUT_DIM;
    localparam int unsigned ColW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CredW    = CntW + 1;
    localparam int unsigned FifoW    = RES_W + 2;

    reader_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [CntW-1:0]     inflight_q, inflight_d;
    logic [RD_LAT-1:0]   vld_q;
    logic [1:0]          tag_q [RD_LAT];
    logic [CntW-1:0]     fifo_count;
    logic                fifo_empty;
    logic [FifoW-1:0]    fifo_head;
    logic [CredW-1:0]    credit;
    logic                issue, last_addr, pop;
    logic signed [RES_W-1:0] shifted;

    // Credit covers both buffered and in-flight reads, so returns never overflow.
    always_comb begin
        credit    = {1'b0, fifo_count} + {1'b0, inflight_q};
        issue     = (state_q == StFetch) && (credit < CredW'(FIFO_DEPTH));
        last_addr = (addr_q == ADDR_W'(NumBeats - 1));
        pop       = m_valid && m_ready;
        inflight_d = inflight_q + CntW'(issue) - CntW'(vld_q[RD_LAT-1]);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StFetch;
                    addr_d  = '0;
                    col_d   = '0;
                end
            end
            StFetch: begin
                if (issue) begin
                    if (last_addr) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        col_d  = (col_q == ColW'(OUT_DIM - 1)) ? '0 : col_q + ColW'(1);
                    end
                end
            end
            StDrain: begin
                if (pop && m_last) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            col_q      <= '0;
            inflight_q <= '0;
            vld_q      <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            inflight_q <= inflight_d;
            vld_q[0]   <= issue;
            tag_q[0]   <= {last_addr, col_q == ColW'(OUT_DIM - 1)};
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    result_fifo #(
        .WIDTH (FifoW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (vld_q[RD_LAT-1]),
        .wr_data ({tag_q[RD_LAT-1], rd_data}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head is gated by valid so the stream reads all-zero while empty or in reset.
    always_comb begin
        rd_en     = issue;
        rd_addr   = addr_q;
        m_valid   = !fifo_empty;
        m_data    = m_valid ? fifo_head[RES_W-1:0] : '0;
        m_row_end = m_valid && fifo_head[RES_W];
        m_last    = m_valid && fifo_head[RES_W+1];
        shifted   = $signed(m_data) >>> SHIFT;
        if (shifted[RES_W-1]) begin
            m_pix = 8'd0;
        end else if (shifted > $signed(RES_W'(255))) begin
            m_pix = 8'hff;
        end else begin
            m_pix = shifted[7:0];
        end
        busy = (state_q == StFetch) || (state_q == StDrain);
        done = (state_q == StDone);
    end

endmodule

// File: tb/tb_conv_result_reader.sv
// Randomised bench for conv_result_reader with a 4x4 map and a 2-cycle BRAM model.
module tb_conv_result_reader;

    localparam int unsigned DIM    = 4;
    localparam int unsigned N      = DIM * DIM;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SHFT   = 0;
    localparam int          BUDGET = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        m_ready = 1'b0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [22:0] rd_data;
    logic        m_valid;
    logic [22:0] m_data;
    logic [7:0]  m_pix;
    logic        m_row_end, m_last, busy, done;

    always #5 clk = ~clk;

    conv_result_reader #(
        .OUT_DIM    (DIM),
        .RD_LAT     (2),
        .FIFO_DEPTH (DEPTH),
        .SHIFT      (SHFT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_pix     (m_pix),
        .m_row_end (m_row_end),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    // Two-stage BRAM: address registered, then output registered.
    logic signed [22:0] mem [N];
    logic [22:0] bram_s1;
    always @(posedge clk) begin
        bram_s1 <= mem[rd_addr[3:0]];
        rd_data <= bram_s1;
    end

    int tests = 0;
    int fails = 0;

    logic [22:0] got_data [$];
    logic [7:0]  got_pix  [$];
    bit          got_re   [$];
    bit          got_last [$];
    int first_valid, last_acc, done_cyc, issued, issued_at20, max_out, stall_err;
    bit rden_at20, done_after_start, busy_after_start;

    function automatic int exp_pix(input int v);
        int s = v >>> SHFT;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic fill_default();
        for (int i = 0; i < N; i++) mem[i] = 23'(i - 3);
    endtask

    // mode: 0 ready=1, 1 toggle, 2 random, 3 held low for 20 cycles then high
    task automatic drive_frame(input int mode, input int extra_start);
        int acc;
        bit r, stalled;
        logic [22:0] pd;
        logic [7:0]  pp;
        logic        pre, pl;
        got_data.delete(); got_pix.delete(); got_re.delete(); got_last.delete();
        first_valid = -1; last_acc = -1; done_cyc = -1; issued = 0; acc = 0;
        max_out = 0; stall_err = 0; stalled = 0; issued_at20 = -1; rden_at20 = 1'b1;
        pd = '0; pp = '0; pre = 1'b0; pl = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            start = (cyc == extra_start);
            if (cyc == 1) begin
                done_after_start = done;
                busy_after_start = busy;
            end
            if (done && cyc > 1) begin
                done_cyc = cyc;
                break;
            end
            if (stalled && (!m_valid || m_data !== pd || m_pix !== pp ||
                            m_row_end !== pre || m_last !== pl)) stall_err++;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (rd_en) issued++;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 1);
                2:       r = ($urandom_range(0, 1) == 1);
                default: r = (cyc > 20);
            endcase
            if (cyc == 20) begin
                issued_at20 = issued;
                rden_at20   = rd_en;
            end
            m_ready = r;
            if (m_valid && r) begin
                got_data.push_back(m_data);
                got_pix.push_back(m_pix);
                got_re.push_back(m_row_end);
                got_last.push_back(m_last);
                acc++;
                last_acc = cyc;
            end
            if (issued - acc > max_out) max_out = issued - acc;
            stalled = m_valid && !r;
            pd = m_data; pp = m_pix; pre = m_row_end; pl = m_last;
        end
        start   = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (rd_en !== 1'b0 || rd_addr !== 16'd0) begin
            fails++;
            $display("FAIL reset_read: rd_en=%b rd_addr=%0d, required 0/0", rd_en, rd_addr);
        end
        tests++;
        if ({m_valid, m_row_end, m_last} !== 3'b000 || m_data !== 23'd0 || m_pix !== 8'd0) begin
            fails++;
            $display("FAIL reset_stream: valid=%b data=%h pix=%h re=%b last=%b, required zeros",
                     m_valid, m_data, m_pix, m_row_end, m_last);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: busy=%b done=%b, required 0/0", busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_start: valid=%b rd_en=%b busy=%b, required 0", m_valid, rd_en,
                     busy);
        end
    endtask

    task automatic test_stream();
        fill_default();
        drive_frame(0, 0);
        tests++;
        if (first_valid !== 4) begin
            fails++;
            $display("FAIL first_valid_cycle: got %0d, required 4", first_valid);
        end
        tests++;
        if (got_data.size() !== N) begin
            fails++;
            $display("FAIL stream_count: got %0d beats, required %0d", got_data.size(), N);
        end
        for (int i = 0; i < got_data.size() && i < N; i++) begin
            tests++;
            if (got_data[i] !== mem[i] || got_pix[i] !== 8'(exp_pix(int'(mem[i]))) ||
                got_re[i] !== (i % DIM == DIM - 1) || got_last[i] !== (i == N - 1)) begin
                fails++;
                $display("FAIL stream_beat%0d: data=%0d pix=%0d re=%b last=%b, required %0d/%0d/%b/%b",
                         i, $signed(got_data[i]), got_pix[i], got_re[i], got_last[i], mem[i],
                         exp_pix(int'(mem[i])), (i % DIM == DIM - 1), (i == N - 1));
            end
        end
        tests++;
        if (last_acc !== 19 || done_cyc !== 20) begin
            fails++;
            $display("FAIL stream_timing: last beat cycle %0d done cycle %0d, required 19/20",
                     last_acc, done_cyc);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL stream_done: done=%b busy=%b, required 1/0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        fill_default();
        drive_frame(1, 0);
        tests++;
        if (got_data.size() !== N || done_cyc < 0) begin
            fails++;
            $display("FAIL bp_count: got %0d beats done_cyc %0d, required %0d and done", got_data.size(),
                     done_cyc, N);
        end
        for (int i = 0; i < got_data.size() && i < N; i++) begin
            tests++;
            if (got_data[i] !== mem[i] || got_re[i] !== (i % DIM == DIM - 1) ||
                got_last[i] !== (i == N - 1)) begin
                fails++;
                $display("FAIL bp_beat%0d: data=%0d re=%b last=%b, required %0d", i,
                         $signed(got_data[i]), got_re[i], got_last[i], mem[i]);
            end
        end
        tests++;
        if (stall_err !== 0 || max_out > DEPTH) begin
            fails++;
            $display("FAIL bp_stability: unstable stalls %0d max outstanding %0d, required 0/<=%0d",
                     stall_err, max_out, DEPTH);
        end
    endtask

    task automatic test_credit_stall();
        fill_default();
        drive_frame(3, 0);
        tests++;
        if (issued_at20 !== 4 || rden_at20 !== 1'b0) begin
            fails++;
            $display("FAIL credit_limit: reads by cycle 20 %0d rd_en %b, required 4/0", issued_at20,
                     rden_at20);
        end
        tests++;
        if (got_data.size() !== N || stall_err !== 0) begin
            fails++;
            $display("FAIL credit_resume: beats %0d unstable %0d, required %0d/0", got_data.size(),
                     stall_err, N);
        end
        for (int i = 0; i < got_data.size() && i < N; i++) begin
            tests++;
            if (got_data[i] !== mem[i]) begin
                fails++;
                $display("FAIL credit_beat%0d: data=%0d, required %0d", i, $signed(got_data[i]), mem[i]);
            end
        end
    endtask

    task automatic test_saturation();
        fill_default();
        mem[5] = 23'(300000);
        mem[6] = 23'(-300000);
        drive_frame(0, 0);
        tests++;
        if (got_data.size() !== N) begin
            fails++;
            $display("FAIL sat_count: got %0d beats, required %0d", got_data.size(), N);
        end else begin
            tests++;
            if (got_pix[5] !== 8'd255 || got_data[5] !== 23'(300000)) begin
                fails++;
                $display("FAIL sat_high: pix=%0d data=%0d, required 255/300000", got_pix[5],
                         $signed(got_data[5]));
            end
            tests++;
            if (got_pix[6] !== 8'd0 || got_data[6] !== 23'(-300000)) begin
                fails++;
                $display("FAIL sat_low: pix=%0d data=%0d, required 0/-300000", got_pix[6],
                         $signed(got_data[6]));
            end
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < N; i++) begin
                int v;
                v = int'($urandom_range(0, 1000)) - 500;
                if ($urandom_range(0, 3) == 0) v = int'($urandom) >>> 9;
                mem[i] = 23'(v);
            end
            drive_frame(2, 0);
            tests++;
            if (got_data.size() !== N || stall_err !== 0 || max_out > DEPTH) begin
                fails++;
                $display("FAIL rand%0d_flow: beats %0d unstable %0d max outstanding %0d", round,
                         got_data.size(), stall_err, max_out);
            end
            for (int i = 0; i < got_data.size() && i < N; i++) begin
                tests++;
                if (got_data[i] !== mem[i] || got_pix[i] !== 8'(exp_pix(int'(mem[i]))) ||
                    got_re[i] !== (i % DIM == DIM - 1) || got_last[i] !== (i == N - 1)) begin
                    fails++;
                    $display("FAIL rand%0d_beat%0d: data=%0d pix=%0d, required %0d/%0d", round, i,
                             $signed(got_data[i]), got_pix[i], mem[i], exp_pix(int'(mem[i])));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit was_valid;
        fill_default();
        @(negedge clk);
        start   = 1'b1;
        m_ready = 1'b1;
        was_valid = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 8) was_valid = m_valid;
        end
        reset = 1'b0;
        #1;
        tests++;
        if (was_valid !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: valid before %b, after valid=%b busy=%b rd_en=%b, required 1/0/0/0",
                     was_valid, m_valid, busy, rd_en);
        end
        @(negedge clk);
        reset   = 1'b1;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_abandon: valid=%b busy=%b done=%b, required 0/0/0", m_valid, busy,
                     done);
        end
        drive_frame(0, 0);
        tests++;
        if (got_data.size() !== N) begin
            fails++;
            $display("FAIL reset_refill_count: got %0d beats, required %0d", got_data.size(), N);
        end
        for (int i = 0; i < got_data.size() && i < N; i++) begin
            tests++;
            if (got_data[i] !== mem[i] || got_last[i] !== (i == N - 1)) begin
                fails++;
                $display("FAIL reset_refill_beat%0d: data=%0d last=%b, required %0d", i,
                         $signed(got_data[i]), got_last[i], mem[i]);
            end
        end
    endtask

    task automatic test_restart();
        int extra;
        fill_default();
        drive_frame(0, 5);
        tests++;
        if (got_data.size() !== N || done_cyc < 0) begin
            fails++;
            $display("FAIL start_in_fetch: got %0d beats done_cyc %0d, required %0d and done",
                     got_data.size(), done_cyc, N);
        end
        for (int i = 0; i < got_data.size() && i < N; i++) begin
            tests++;
            if (got_data[i] !== mem[i]) begin
                fails++;
                $display("FAIL fetch_restart_beat%0d: data=%0d, required %0d", i,
                         $signed(got_data[i]), mem[i]);
            end
        end
        extra = 0;
        m_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (m_valid || !done) extra++;
        end
        m_ready = 1'b0;
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL done_quiet: %0d cycles with extra beats or done low, required 0", extra);
        end
        drive_frame(0, 0);
        tests++;
        if (done_after_start !== 1'b0 || busy_after_start !== 1'b1) begin
            fails++;
            $display("FAIL start_in_done: done=%b busy=%b after start, required 0/1",
                     done_after_start, busy_after_start);
        end
        tests++;
        if (got_data.size() !== N) begin
            fails++;
            $display("FAIL second_frame_count: got %0d beats, required %0d", got_data.size(), N);
        end
        for (int i = 0; i < got_data.size() && i < N; i++) begin
            tests++;
            if (got_data[i] !== mem[i] || got_re[i] !== (i % DIM == DIM - 1)) begin
                fails++;
                $display("FAIL second_frame_beat%0d: data=%0d re=%b, required %0d", i,
                         $signed(got_data[i]), got_re[i], mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_credit_stall();
        test_saturation();
        test_random();
        test_reset_mid();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
